// File: rtl/register_bank.sv
// Write-back register file: two registered read ports and a debug port with
// same-edge write bypass, a pending-load scoreboard driving stall, and a commit counter.
module register_bank #(
    parameter int B  = 32,
    parameter int D  = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          RegWrite,
    input  logic [D-1:0]  write_reg,
    input  logic [B-1:0]  write_data,
    input  logic [D-1:0]  read_reg_a,
    input  logic [D-1:0]  read_reg_b,
    output logic [B-1:0]  read_data_a,
    output logic [B-1:0]  read_data_b,
    input  logic          load_issue,
    input  logic [D-1:0]  load_dest,
    output logic          stall,
    input  logic [D-1:0]  dbg_addr,
    output logic [B-1:0]  dbg_data,
    output logic [CW-1:0] write_count
);
    localparam int N = 1 << D;

    logic [B-1:0]   regs_q [N];
    logic [N-1:0]   pending_q, pending_d;
    logic [CW-1:0]  count_q;
    logic           commit;
    logic           load_ok;
    logic           hit_a, hit_b;
    logic [3*D-1:0] addr_bus;

    assign commit   = RegWrite && (write_reg != '0);
    assign addr_bus = {dbg_addr, read_reg_b, read_reg_a};

    // r0 is never written because commit excludes it; its read path forces 0 anyway.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) regs_q[i] <= '0;
            count_q <= '0;
        end else if (commit) begin
            regs_q[write_reg] <= write_data;
            count_q           <= count_q + 1'b1;
        end
    end

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_port
        logic [D-1:0] addr;
        logic [B-1:0] data_d, data_q;

        assign addr = addr_bus[gi*D +: D];

        always_comb begin
            data_d = regs_q[addr];
            if (RegWrite && write_reg == addr) data_d = write_data;
            if (addr == '0) data_d = '0;
        end

        always_ff @(posedge clk) begin
            if (reset) data_q <= '0;
            else       data_q <= data_d;
        end
    end

    assign read_data_a = g_port[0].data_q;
    assign read_data_b = g_port[1].data_q;
    assign dbg_data    = g_port[2].data_q;
    assign write_count = count_q;

    // A write-back landing this cycle covers the hazard via the bypass.
    assign hit_a = (read_reg_a != '0) && pending_q[read_reg_a]
                   && !(RegWrite && write_reg == read_reg_a);
    assign hit_b = (read_reg_b != '0) && pending_q[read_reg_b]
                   && !(RegWrite && write_reg == read_reg_b);
    assign stall = !reset && (hit_a || hit_b);

    assign load_ok = load_issue && (load_dest != '0) && !stall;

    for (gi = 0; gi < N; gi++) begin : g_pend
        if (gi == 0) begin : g_zero
            assign pending_d[gi] = 1'b0;
        end else begin : g_bit
            // Set after clear: a newer load to the same register stays outstanding.
            assign pending_d[gi] = (load_ok && load_dest == D'(gi))
                                   || (pending_q[gi] && !(commit && write_reg == D'(gi)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pending_d;
    end
endmodule

// File: tb/tb_register_bank.sv
// Scoreboarded bench for register_bank: expectations are queued as stimulus is
// driven and compared against outputs captured after the corresponding edge.
module tb_register_bank;
    localparam int B = 32, D = 5, CW = 4;

    logic          clk = 1'b0;
    logic          reset, RegWrite, load_issue, stall;
    logic [D-1:0]  write_reg, read_reg_a, read_reg_b, load_dest, dbg_addr;
    logic [B-1:0]  write_data, read_data_a, read_data_b, dbg_data;
    logic [CW-1:0] write_count;

    register_bank #(.B(B), .D(D), .CW(CW)) dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .write_reg(write_reg),
        .write_data(write_data), .read_reg_a(read_reg_a), .read_reg_b(read_reg_b),
        .read_data_a(read_data_a), .read_data_b(read_data_b), .load_issue(load_issue),
        .load_dest(load_dest), .stall(stall), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .write_count(write_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;     // 0 read_data_a, 1 read_data_b, 2 dbg_data, 3 write_count
        int          cyc;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] hist [0:4095][0:3];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_pend;
    int          m_cnt;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (RegWrite && write_reg == a) return write_data;
        return m_regs[a];
    endfunction

    function automatic logic m_stall();
        logic sa, sb_;
        if (reset) return 1'b0;
        sa  = (read_reg_a != 0) && m_pend[read_reg_a] && !(RegWrite && write_reg == read_reg_a);
        sb_ = (read_reg_b != 0) && m_pend[read_reg_b] && !(RegWrite && write_reg == read_reg_b);
        return sa || sb_;
    endfunction

    task automatic push(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name; e.sel = sel; e.cyc = cyc + 1; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic idle();
        reset = 1'b0; RegWrite = 1'b0; write_reg = '0; write_data = '0;
        read_reg_a = '0; read_reg_b = '0; load_issue = 1'b0; load_dest = '0; dbg_addr = '0;
    endtask

    // Queue model expectations for this edge, advance the model, clock, capture outputs.
    task automatic step(input string tag);
        logic st;
        st = m_stall();
        if (reset) begin
            push({tag, "_a"}, 0, 32'h0);
            push({tag, "_b"}, 1, 32'h0);
            push({tag, "_dbg"}, 2, 32'h0);
            push({tag, "_cnt"}, 3, 32'h0);
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_pend = '0;
            m_cnt  = 0;
        end else begin
            push({tag, "_a"}, 0, m_read(read_reg_a));
            push({tag, "_b"}, 1, m_read(read_reg_b));
            push({tag, "_dbg"}, 2, m_read(dbg_addr));
            if (RegWrite && write_reg != 0) begin
                m_regs[write_reg] = write_data;
                m_cnt = (m_cnt + 1) % 16;
                m_pend[write_reg] = 1'b0;
            end
            if (load_issue && load_dest != 0 && !st) m_pend[load_dest] = 1'b1;
            push({tag, "_cnt"}, 3, 32'(m_cnt));
        end
        @(posedge clk);
        #1;
        cyc++;
        hist[cyc][0] = read_data_a;
        hist[cyc][1] = read_data_b;
        hist[cyc][2] = dbg_data;
        hist[cyc][3] = {28'h0, write_count};
    endtask

    task automatic test_reset();
        exp_t e;
        idle();
        reset = 1'b1; RegWrite = 1'b1; write_reg = 5'd3; write_data = 32'hDEADBEEF;
        read_reg_a = 5'd3; load_issue = 1'b1; load_dest = 5'd3;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_stall: got %b expected 0", stall);
        end
        push("rst_a_zero", 0, 32'h0);
        push("rst_cnt_zero", 3, 32'h0);
        step("rst");
        idle();
        read_reg_a = 5'd3;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_load_ignored: got %b expected 0", stall);
        end
        push("rst_r3_read", 0, 32'h0);
        step("post_rst");
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (hist[e.cyc][e.sel] !== e.exp) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got %h expected %h", e.name, e.cyc, hist[e.cyc][e.sel], e.exp);
            end
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        idle();
        RegWrite = 1'b1; write_reg = 5'd5; write_data = 32'h12345678;
        step("wr_r5");
        idle();
        read_reg_a = 5'd5;
        push("rd_r5", 0, 32'h12345678);
        step("rd_r5");
        idle();
        RegWrite = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF;
        step("wr_r0");
        idle();
        read_reg_a = 5'd0; dbg_addr = 5'd0;
        push("rd_r0", 0, 32'h0);
        push("dbg_r0", 2, 32'h0);
        push("cnt_one", 3, 32'h1);
        step("rd_r0");
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (hist[e.cyc][e.sel] !== e.exp) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got %h expected %h", e.name, e.cyc, hist[e.cyc][e.sel], e.exp);
            end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        idle();
        RegWrite = 1'b1; write_reg = 5'd7; write_data = 32'hA5A5A5A5;
        read_reg_a = 5'd7; read_reg_b = 5'd7; dbg_addr = 5'd7;
        push("byp_a", 0, 32'hA5A5A5A5);
        push("byp_b", 1, 32'hA5A5A5A5);
        push("byp_dbg", 2, 32'hA5A5A5A5);
        step("byp");
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (hist[e.cyc][e.sel] !== e.exp) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got %h expected %h", e.name, e.cyc, hist[e.cyc][e.sel], e.exp);
            end
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        idle();
        load_issue = 1'b1; load_dest = 5'd9;
        step("ld9");
        idle();
        read_reg_b = 5'd9;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (stall !== 1'b1) begin
                n_fail++; $display("FAIL lu_stall_hold%0d: got %b expected 1", i, stall);
            end
            step("lu_hold");
        end
        RegWrite = 1'b1; write_reg = 5'd9; write_data = 32'h55;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL lu_wb_release: got %b expected 0", stall);
        end
        push("lu_b_bypass", 1, 32'h55);
        step("lu_wb");
        idle();
        read_reg_b = 5'd9;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL lu_cleared: got %b expected 0", stall);
        end
        step("lu_after");
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (hist[e.cyc][e.sel] !== e.exp) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got %h expected %h", e.name, e.cyc, hist[e.cyc][e.sel], e.exp);
            end
        end
    endtask

    task automatic test_set_clear();
        exp_t e;
        idle();
        load_issue = 1'b1; load_dest = 5'd4;
        RegWrite = 1'b1; write_reg = 5'd4; write_data = 32'hCAFEF00D;
        step("sc_edge");
        idle();
        read_reg_a = 5'd4; dbg_addr = 5'd4;
        load_issue = 1'b1; load_dest = 5'd6;   // must be dropped: decode is stalled
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL sc_set_wins: got %b expected 1", stall);
        end
        push("sc_dbg", 2, 32'hCAFEF00D);
        step("sc_read");
        idle();
        read_reg_a = 5'd6;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL sc_load_while_stall: got %b expected 0", stall);
        end
        RegWrite = 1'b1; write_reg = 5'd4; write_data = 32'h4444;
        step("sc_clr");
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (hist[e.cyc][e.sel] !== e.exp) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got %h expected %h", e.name, e.cyc, hist[e.cyc][e.sel], e.exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        idle();
        load_issue = 1'b1; load_dest = 5'd12;
        step("rm_ld");
        idle();
        read_reg_a = 5'd12;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL rm_pending: got %b expected 1", stall);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL rm_stall_in_reset: got %b expected 0", stall);
        end
        step("rm_rst");
        reset = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL rm_forgotten: got %b expected 0", stall);
        end
        push("rm_r5_cleared", 0, 32'h0);
        read_reg_a = 5'd5;
        step("rm_post");
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (hist[e.cyc][e.sel] !== e.exp) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got %h expected %h", e.name, e.cyc, hist[e.cyc][e.sel], e.exp);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        idle();
        for (int i = 1; i <= 16; i++) begin
            RegWrite = 1'b1;
            write_reg = (i == 16) ? 5'd1 : 5'(i);
            write_data = 32'h01010101 * i;
            if (i == 15) push("wrap_cnt15", 3, 32'd15);
            if (i == 16) push("wrap_cnt0", 3, 32'd0);
            step("wrap");
        end
        idle();
        read_reg_a = 5'd1; read_reg_b = 5'd15;
        push("wrap_r1", 0, 32'h10101010);
        push("wrap_r15", 1, 32'h0F0F0F0F);
        step("wrap_rd");
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (hist[e.cyc][e.sel] !== e.exp) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got %h expected %h", e.name, e.cyc, hist[e.cyc][e.sel], e.exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic exp_st;
        for (int n = 0; n < 300; n++) begin
            idle();
            RegWrite   = ($urandom_range(0, 1) == 1);
            write_reg  = 5'($urandom_range(0, 31));
            write_data = $urandom;
            read_reg_a = 5'($urandom_range(0, 31));
            read_reg_b = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            dbg_addr   = 5'($urandom_range(0, 31));
            load_issue = ($urandom_range(0, 3) == 0);
            load_dest  = 5'($urandom_range(0, 31));
            #1;
            exp_st = m_stall();
            n_checks++;
            if (stall !== exp_st) begin
                n_fail++; $display("FAIL b2b_stall cyc %0d: got %b expected %b", cyc, stall, exp_st);
            end
            step("b2b");
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (hist[e.cyc][e.sel] !== e.exp) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got %h expected %h", e.name, e.cyc, hist[e.cyc][e.sel], e.exp);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        m_pend = '0;
        m_cnt  = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_bypass();
        test_load_use();
        test_set_clear();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
